// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder and its storage array:
//   - data / address width constants
//   - access size codes (B/H/W/D), same encoding as the MEM-stage size field
//   - FSM state encoding
//   - helpers for byte-lane mask generation and alignment checking
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;
   localparam int BYTES  = DATA_W / 8;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Unshifted byte mask for an access of the given size.
   function automatic logic [BYTES-1:0] size_mask(input logic [1:0] size);
      logic [BYTES-1:0] mask;
      case (size)
         SIZE_B:  mask = 8'h01;
         SIZE_H:  mask = 8'h03;
         SIZE_W:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // Natural alignment check on the low three address bits.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lsb);
      logic bad;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = lsb[0];
         SIZE_W:  bad = |lsb[1:0];
         default: bad = |lsb;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// -----------------------------------------------------------------------------
// dmem_sram
// Synchronous single-port DEPTH x 64 storage with per-byte write enables and a
// registered read port. Each byte lane is its own array so that every lane maps
// onto a plain block RAM with a simple write enable. Contents are not reset.
//   clock  : rising-edge clock
//   en     : read enable; rdata captures mem[addr] at the edge when set
//   we     : byte write enables (bit i writes wdata[8*i+7:8*i])
//   addr   : doubleword index
//   wdata  : write data, already lane-aligned
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module dmem_sram
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              en,
   input  logic [BYTES-1:0]  we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] lane_q_reg;

         always_ff @(posedge clock) begin
            if (we[gi]) begin
               lane_mem[addr] <= wdata[8*gi +: 8];
            end
            if (en) begin
               lane_q_reg <= lane_mem[addr];
            end
         end

         assign rdata[8*gi +: 8] = lane_q_reg;
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for MEM-stage data requests. Accepts one load/store at
// a time, waits a fixed LATENCY, then presents the response until the requester
// takes it. Performs size/alignment and address-range checking and byte-lane
// masking for stores.
//   clock       : sole clock, rising edge
//   reset       : asynchronous, active-low reset
//   req_valid   : request present
//   req_ready   : responder can accept a request (IDLE only)
//   req_wr      : 1 = store, 0 = load
//   req_size    : 0=B 1=H 2=W 3=D
//   req_addr    : byte address
//   req_wdata   : store data, right-aligned
//   resp_valid  : response present
//   resp_ready  : requester accepts response
//   resp_rdata  : full doubleword for loads; 0 for stores and errors
//   resp_err    : misaligned or out-of-range access
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int                DEPTH     = 1024,
   parameter int                LATENCY   = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int                IDX_W = $clog2(DEPTH);
   localparam int                CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH) << 3;

   state_e              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic                ready_reg;
   logic                valid_reg;
   logic                err_reg;
   logic                load_reg;   // response carries load data

   logic                wr_reg;
   logic [1:0]          size_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;

   logic                in_idle;
   logic                cur_wr;
   logic [1:0]          cur_size;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_wdata;
   logic [ADDR_W-1:0]   offset;
   logic                out_of_range;
   logic                misaligned;
   logic                cur_err;
   logic                accept;
   logic                fire;
   logic                sram_en;
   logic [IDX_W-1:0]    index;
   logic [BYTES-1:0]    lane_mask;
   logic [BYTES-1:0]    byte_we;
   logic [DATA_W-1:0]   lane_data;
   logic [DATA_W-1:0]   sram_rdata;

   // The memory access happens on the edge entering RESP. With LATENCY==1 that
   // is the acceptance edge itself, so in IDLE the live request fields are used.
   always_comb begin
      in_idle   = (state_reg == ST_IDLE);
      cur_wr    = in_idle ? req_wr    : wr_reg;
      cur_size  = in_idle ? req_size  : size_reg;
      cur_addr  = in_idle ? req_addr  : addr_reg;
      cur_wdata = in_idle ? req_wdata : wdata_reg;
   end

   assign offset       = cur_addr - BASE_ADDR;
   assign out_of_range = (cur_addr < BASE_ADDR) || (offset >= SPAN);
   assign misaligned   = is_misaligned(cur_size, cur_addr[2:0]);
   assign cur_err      = out_of_range | misaligned;
   assign index        = offset[IDX_W+2:3];
   assign lane_mask    = size_mask(cur_size) << cur_addr[2:0];
   assign lane_data    = cur_wdata << {cur_addr[2:0], 3'b000};

   assign accept  = in_idle & ready_reg & req_valid;
   assign fire    = ((state_reg == ST_WAIT) && (cnt_reg == '0)) || ((LATENCY == 1) && accept);
   assign sram_en = fire & ~cur_err;
   assign byte_we = (sram_en & cur_wr) ? lane_mask : '0;

   dmem_sram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_sram (
      .clock (clock),
      .en    (sram_en),
      .we    (byte_we),
      .addr  (index),
      .wdata (lane_data),
      .rdata (sram_rdata)
   );

   // Request capture; plain data registers, qualified by the handshake.
   always_ff @(posedge clock) begin
      if (accept) begin
         wr_reg    <= req_wr;
         size_reg  <= req_size;
         addr_reg  <= req_addr;
         wdata_reg <= req_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         ready_reg <= 1'b0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         load_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!ready_reg) begin
                  // first edge after reset release
                  ready_reg <= 1'b1;
               end else if (req_valid) begin
                  ready_reg <= 1'b0;
                  if (LATENCY == 1) begin
                     state_reg <= ST_RESP;
                     valid_reg <= 1'b1;
                     err_reg   <= cur_err;
                     load_reg  <= ~cur_wr & ~cur_err;
                  end else begin
                     state_reg <= ST_WAIT;
                     cnt_reg   <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_reg == '0) begin
                  state_reg <= ST_RESP;
                  valid_reg <= 1'b1;
                  err_reg   <= cur_err;
                  load_reg  <= ~cur_wr & ~cur_err;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state_reg <= ST_IDLE;
                  valid_reg <= 1'b0;
                  err_reg   <= 1'b0;
                  load_reg  <= 1'b0;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = ready_reg;
   assign resp_valid = valid_reg;
   assign resp_err   = err_reg;
   // SRAM read register only updates on the RESP-entry edge, so this is stable
   // for the whole RESP state.
   assign resp_rdata = load_reg ? sram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int          DEPTH   = 1024;
   localparam int          LATENCY = 2;
   localparam logic [63:0] BASE    = 64'h8000_0000;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [1:0]  req_size;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_responder #(
      .DEPTH     (DEPTH),
      .LATENCY   (LATENCY),
      .BASE_ADDR (BASE)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_size   (req_size),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        exp_err;
      logic [63:0] exp_rdata;
   } txn_t;

   txn_t vecs[$];

   function automatic txn_t mk(input logic wr, input logic [1:0] size, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic err, input logic [63:0] rdata);
      txn_t t;
      t.wr        = wr;
      t.size      = size;
      t.addr      = addr;
      t.wdata     = wdata;
      t.exp_err   = err;
      t.exp_rdata = rdata;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic issue(input logic wr, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("accept_ready", {63'd0, req_ready}, 64'd1);
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   // Counts clock edges after acceptance until resp_valid is seen.
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 50) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic run_txn(input txn_t t, input int idx);
      int lat;
      issue(t.wr, t.size, t.addr, t.wdata);
      wait_resp(lat);
      check("latency", 64'(lat), 64'(LATENCY));
      check("resp_valid", {63'd0, resp_valid}, 64'd1);
      check("resp_err", {63'd0, resp_err}, {63'd0, t.exp_err});
      check("resp_rdata", resp_rdata, t.exp_rdata);
      check("req_ready_busy", {63'd0, req_ready}, 64'd0);
      $display("txn %0d: wr=%0d size=%0d addr=0x%h wdata=0x%h -> rdata=0x%h err=%0d lat=%0d",
               idx, t.wr, t.size, t.addr, t.wdata, resp_rdata, resp_err, lat);
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check("resp_valid_drop", {63'd0, resp_valid}, 64'd0);
      check("req_ready_back", {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [63:0] held;

      vecs.push_back(mk(1, 2'd3, 64'h8000_0008, 64'h1122_3344_5566_7788, 0, 64'h0));
      vecs.push_back(mk(0, 2'd3, 64'h8000_0008, 64'h0, 0, 64'h1122_3344_5566_7788));
      vecs.push_back(mk(1, 2'd0, 64'h8000_000B, 64'hFFFF_FFFF_FFFF_FFAB, 0, 64'h0));
      vecs.push_back(mk(0, 2'd3, 64'h8000_0008, 64'h0, 0, 64'h1122_3344_AB66_7788));
      vecs.push_back(mk(1, 2'd3, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 0, 64'h0));
      vecs.push_back(mk(1, 2'd1, 64'h8000_0001, 64'h0000_0000_0000_FFFF, 1, 64'h0));
      vecs.push_back(mk(0, 2'd3, 64'h8000_0000, 64'h0, 0, 64'h0123_4567_89AB_CDEF));
      vecs.push_back(mk(0, 2'd3, 64'h7FFF_FFF8, 64'h0, 1, 64'h0));
      vecs.push_back(mk(0, 2'd3, 64'h8000_2000, 64'h0, 1, 64'h0));
      vecs.push_back(mk(1, 2'd2, 64'h8000_0002, 64'h0000_0000_FFFF_FFFF, 1, 64'h0));
      vecs.push_back(mk(1, 2'd3, 64'h8000_0004, 64'h0, 1, 64'h0));
      vecs.push_back(mk(1, 2'd1, 64'h8000_000E, 64'h0000_0000_0000_9999, 0, 64'h0));
      vecs.push_back(mk(0, 2'd0, 64'h8000_0009, 64'h0, 0, 64'h9999_3344_AB66_7788));
      vecs.push_back(mk(1, 2'd3, 64'h8000_1FF8, 64'hCAFE_F00D_1234_5678, 0, 64'h0));
      vecs.push_back(mk(1, 2'd2, 64'h8000_1FFC, 64'h0000_0000_DEAD_BEEF, 0, 64'h0));
      vecs.push_back(mk(0, 2'd2, 64'h8000_1FF8, 64'h0, 0, 64'hDEAD_BEEF_1234_5678));
      vecs.push_back(mk(1, 2'd3, 64'h8000_0010, 64'h5A5A_5A5A_5A5A_5A5A, 0, 64'h0));
      vecs.push_back(mk(0, 2'd3, 64'h8000_0010, 64'h0, 0, 64'h5A5A_5A5A_5A5A_5A5A));

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_size   = 2'd0;
      req_addr   = 64'h0;
      req_wdata  = 64'h0;
      resp_ready = 1'b0;

      // Reset behaviour, with a request pending that must be ignored.
      repeat (3) @(negedge clock);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_size  = 2'd3;
      req_addr  = 64'h8000_0000;
      @(negedge clock);
      check("rst_req_ready", {63'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'h0);
      check("rst_resp_err", {63'd0, resp_err}, 64'd0);
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      check("release_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clock);
      check("ready_after_release", {63'd0, req_ready}, 64'd1);
      check("valid_after_release", {63'd0, resp_valid}, 64'd0);

      foreach (vecs[i]) run_txn(vecs[i], i);

      // Backpressure: response held for 5 cycles with a competing request.
      issue(1'b0, 2'd3, 64'h8000_0008, 64'h0);
      wait_resp(lat);
      check("bp_latency", 64'(lat), 64'(LATENCY));
      held = resp_rdata;
      check("bp_rdata", held, 64'h9999_3344_AB66_7788);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_size  = 2'd3;
      req_addr  = 64'h8000_0008;
      req_wdata = 64'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
         check("bp_rdata_hold", resp_rdata, 64'h9999_3344_AB66_7788);
         check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      check("bp_valid_drop", {63'd0, resp_valid}, 64'd0);
      check("bp_ready_back", {63'd0, req_ready}, 64'd1);
      @(negedge clock);
      check("bp_no_spurious", {63'd0, resp_valid}, 64'd0);
      check("bp_still_ready", {63'd0, req_ready}, 64'd1);
      $display("txn bp: held rdata=0x%h for 5 cycles", held);
      run_txn(mk(0, 2'd3, 64'h8000_0008, 64'h0, 0, 64'h9999_3344_AB66_7788), 100);

      // Reset during WAIT aborts a store.
      issue(1'b1, 2'd3, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF);
      reset = 1'b0;
      #1;
      check("abort_req_ready", {63'd0, req_ready}, 64'd0);
      check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("abort_resp_rdata", resp_rdata, 64'h0);
      check("abort_resp_err", {63'd0, resp_err}, 64'd0);
      repeat (3) begin
         @(negedge clock);
         check("abort_hold_ready", {63'd0, req_ready}, 64'd0);
         check("abort_hold_valid", {63'd0, resp_valid}, 64'd0);
      end
      reset = 1'b1;
      @(negedge clock);
      check("abort_ready_release", {63'd0, req_ready}, 64'd1);
      $display("txn abort: store to 0x8000_0010 interrupted by reset");
      run_txn(mk(0, 2'd3, 64'h8000_0010, 64'h0, 0, 64'h5A5A_5A5A_5A5A_5A5A), 101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
